seg_sequence_decoder: RTL and testbench
=======================================

Name: seg_sequence_decoder

Overview:
- Reads an 8-bit seven-segment bus (bit7 = decimal point, bits[6:0] = segments g..a) driven by the 1-2-4-8 display counter.
- Decodes the bus back to the displayed value and filters short glitches.
- Checks that accepted digits follow the cyclic sequence 1→2→4→8→1 and counts sequence violations.
- Sits on the board top level beside the counter, as its receiving end; outputs go to LEDs/LCD debug fields.

Parameters:
- NBITS_SEG, 8, width of the segment bus.
- STABLE_CYCLES, 2, consecutive identical samples required to accept a pattern (min 1).
- LOCK_COUNT, 2, consecutive correct transitions required to assert locked.
- NBITS_ERR, 8, width of the saturating error counter.

Ports:
- clk_2  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- sample_en  in  1  sample qualifier; when 0, all state holds
- seg_in  in  NBITS_SEG  segment pattern under observation
- clear_err  in  1  synchronous clear of err_count
- value  out  4  decoded digit (1, 2, 4 or 8); 0 when invalid
- code_idx  out  2  index of the digit: 1→0, 2→1, 4→2, 8→3
- value_valid  out  1  last accepted pattern was a legal code
- accepted  out  1  one-cycle pulse per accepted pattern
- locked  out  1  sequence tracking is established
- seq_error  out  1  one-cycle pulse on a sequence violation while locked
- err_count  out  NBITS_ERR  saturating count of violations

Behaviour:
- Clocking and reset: one clock, clk_2; reset is asynchronous, active-low (reset_n). Reset drives every output to 0, the FSM to HUNT, and all counters and history to 0.
- Code table, on bits[6:0]: 0x06 = 1, 0x5B = 2, 0x66 = 4, 0x7F = 8. Any other pattern is invalid.
- Stability filter, evaluated on rising edges of clk_2 where sample_en = 1:
  - If the sample equals the previous sample, stab_cnt increments, saturating at STABLE_CYCLES. Otherwise stab_cnt = 1.
  - On the edge where stab_cnt first reaches STABLE_CYCLES: accepted = 1 for one cycle, and value, code_idx and value_valid update on that same edge.
  - Latency: a new pattern is reflected STABLE_CYCLES sampling edges after it first appears.
  - Exactly one accept per stable run.
- Repeat rule: an accepted valid code equal to the previously accepted valid code (a glitch return) is ignored by the FSM. It produces no error and no match.
- FSM states: HUNT, SYNC, LOCKED.
  - HUNT: valid accept → store prev_idx, match_cnt = 0, go to SYNC. Invalid accept → stay in HUNT.
  - SYNC: accept with idx == (prev_idx + 1) mod 4 → match_cnt++; when match_cnt reaches LOCK_COUNT, go to LOCKED. Valid mismatch → prev_idx = idx, match_cnt = 0, stay in SYNC. Invalid accept → go to HUNT.
  - LOCKED: correct successor → stay, prev_idx updated. Mismatch or invalid → seq_error pulse, err_count++, go to HUNT.
- locked = 1 only in LOCKED; it is registered and deasserts on the edge of the violating accept.
- err_count saturates at all ones. clear_err has priority over a simultaneous increment, so the result is 0.
- Wrap-around: idx 3 → 0 (8 → 1) is a correct transition.
- Reset mid-operation: immediate return to the reset state. The first accept after release takes the HUNT path.

Optional Feature:
- Macro: SEG_DP_CHECK_EN.
- Defined: seg_in[7] must be 0; a pattern with bit7 = 1 is invalid.
- Undefined: bit7 is masked before both the stability compare and decoding.

Decomposition:
- Package seg_dec_pkg holds:
  - the state enum (HUNT, SYNC, LOCKED);
  - the code constants SEG_CODE_1/2/4/8;
  - a 2-bit idx typedef;
  - the digit lookup (idx → 1, 2, 4, 8).
- Sub-module seg7_code_decoder: combinational pattern → {valid, idx}, honouring SEG_DP_CHECK_EN.

Test Plan (defaults STABLE_CYCLES = 2, LOCK_COUNT = 2):
- Nominal: drive 0x06, 0x5B, 0x66, 0x7F, each held 2 sample edges → value 1, 2, 4, 8; locked rises with the 0x66 accept; err_count = 0. Continue 0x06 → locked stays high (wrap).
- Skip: while locked, drive 0x06 then 0x66 → seq_error pulse of 1 cycle, err_count = 1, locked = 0, FSM in HUNT.
- Glitch: while locked on 0x5B, insert a single 0x00 sample, then 0x5B again → no accept of 0x00, no error, locked stays 1.
- Invalid: while locked, hold 0x3F for 2 edges → value = 0, value_valid = 0, seq_error, err_count increments. With sample_en = 0 held, the outputs freeze.
- Saturation and reset: force err_count to 255 plus another violation → stays 255. Violation with clear_err = 1 → 0. Pulse reset_n low mid-run → all outputs 0 asynchronously.
- Macro: with SEG_DP_CHECK_EN, 0x86 held → invalid. Without the macro, 0x86 decodes as value = 1.

Source files
------------

// File: rtl/seg_dec_pkg.sv
// Shared types and constants for the seven-segment sequence decoder:
// tracker states, segment codes of the 1-2-4-8 counter and the digit lookup.
package seg_dec_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

    typedef logic [1:0] seg_idx_t;

    localparam logic [6:0] SEG_CODE_1 = 7'h06;
    localparam logic [6:0] SEG_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG_CODE_4 = 7'h66;
    localparam logic [6:0] SEG_CODE_8 = 7'h7F;

    // Digits are powers of two, so the index is simply the shift amount.
    function automatic logic [3:0] idx_to_digit(seg_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/seg_sequence_decoder_if.sv
// Bus between the segment source/debug sink and seg_sequence_decoder.
// master drives the sampled segment bus and controls, slave returns the decode.
interface seg_sequence_decoder_if #(
    parameter int NBITS_SEG = 8,
    parameter int NBITS_ERR = 8
);
    logic                 sample_en;
    logic [NBITS_SEG-1:0] seg_in;
    logic                 clear_err;
    logic [3:0]           value;
    logic [1:0]           code_idx;
    logic                 value_valid;
    logic                 accepted;
    logic                 locked;
    logic                 seq_error;
    logic [NBITS_ERR-1:0] err_count;

    modport master (
        output sample_en, seg_in, clear_err,
        input  value, code_idx, value_valid, accepted, locked, seq_error, err_count
    );

    modport slave (
        input  sample_en, seg_in, clear_err,
        output value, code_idx, value_valid, accepted, locked, seq_error, err_count
    );
endinterface

// File: rtl/seg7_code_decoder.sv
// Combinational segment pattern -> {valid, idx}. With SEG_DP_CHECK_EN defined a lit
// decimal point makes the pattern invalid; otherwise bit7 is masked off here.
module seg7_code_decoder
    import seg_dec_pkg::*;
#(
    parameter int NBITS_SEG = 8
) (
    input  logic [NBITS_SEG-1:0] seg,
    output logic [NBITS_SEG-1:0] seg_masked,
    output logic                 valid,
    output seg_idx_t             idx
);
    localparam logic [NBITS_SEG-1:0] DP_MASK = NBITS_SEG'(8'h80);

`ifdef SEG_DP_CHECK_EN
    assign seg_masked = seg;
`else
    assign seg_masked = seg & ~DP_MASK;
`endif

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        if (seg_masked[NBITS_SEG-1:7] == '0) begin
            case (seg_masked[6:0])
                SEG_CODE_1: begin valid = 1'b1; idx = 2'd0; end
                SEG_CODE_2: begin valid = 1'b1; idx = 2'd1; end
                SEG_CODE_4: begin valid = 1'b1; idx = 2'd2; end
                SEG_CODE_8: begin valid = 1'b1; idx = 2'd3; end
                default:    begin valid = 1'b0; idx = 2'd0; end
            endcase
        end
    end
endmodule

// File: rtl/seg_sequence_decoder.sv
// Receiving end of the 1-2-4-8 display counter: glitch-filters the segment bus,
// decodes it and checks the cyclic 1->2->4->8->1 order, counting violations.
module seg_sequence_decoder
    import seg_dec_pkg::*;
#(
    parameter int NBITS_SEG     = 8,
    parameter int STABLE_CYCLES = 2,
    parameter int LOCK_COUNT    = 2,
    parameter int NBITS_ERR     = 8
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    seg_sequence_decoder_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

    logic [NBITS_SEG-1:0] sample, prev_sample;
    logic [SW-1:0]        stab_cnt, stab_next;
    logic                 same, accept_now;
    logic                 dec_valid, repeat_hit, is_succ, violation;
    seg_idx_t             dec_idx, prev_idx;
    logic [MW-1:0]        match_cnt;
    seq_state_t           state;

    seg7_code_decoder #(.NBITS_SEG(NBITS_SEG)) u_code (
        .seg        (bus.seg_in),
        .seg_masked (sample),
        .valid      (dec_valid),
        .idx        (dec_idx)
    );

    assign same       = (sample == prev_sample);
    assign stab_next  = same ? ((stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + SW'(1)) : SW'(1);
    // Accept only on the edge the run length first hits the threshold.
    assign accept_now = bus.sample_en && (stab_next == STAB_MAX) && (!same || stab_cnt != STAB_MAX);
    assign repeat_hit = dec_valid && bus.value_valid && (dec_idx == bus.code_idx);
    assign is_succ    = dec_valid && (dec_idx == seg_idx_t'(prev_idx + 2'd1));
    assign violation  = accept_now && !repeat_hit && (state == LOCKED) && !is_succ;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample <= '0;
            stab_cnt    <= '0;
        end else if (bus.sample_en) begin
            prev_sample <= sample;
            stab_cnt    <= stab_next;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= HUNT;
            prev_idx        <= '0;
            match_cnt       <= '0;
            bus.value       <= '0;
            bus.code_idx    <= '0;
            bus.value_valid <= 1'b0;
            bus.accepted    <= 1'b0;
            bus.locked      <= 1'b0;
            bus.seq_error   <= 1'b0;
            bus.err_count   <= '0;
        end else begin
            bus.accepted  <= accept_now;
            bus.seq_error <= violation;
            if (accept_now) begin
                bus.value       <= dec_valid ? idx_to_digit(dec_idx) : 4'd0;
                bus.code_idx    <= dec_valid ? dec_idx : 2'd0;
                bus.value_valid <= dec_valid;
            end
            // Glitch returns to the last accepted code are invisible to the tracker.
            if (accept_now && !repeat_hit) begin
                case (state)
                    HUNT: begin
                        if (dec_valid) begin
                            prev_idx  <= dec_idx;
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (!dec_valid) begin
                            state <= HUNT;
                        end else if (is_succ) begin
                            prev_idx  <= dec_idx;
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end
                        end else begin
                            prev_idx  <= dec_idx;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (is_succ) begin
                            prev_idx <= dec_idx;
                        end else begin
                            state      <= HUNT;
                            bus.locked <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
            if (bus.clear_err)
                bus.err_count <= '0;
            else if (violation && bus.err_count != '1)
                bus.err_count <= bus.err_count + NBITS_ERR'(1);
        end
    end
endmodule

// File: tb/tb_seg_sequence_decoder.sv
// Self-checking bench for seg_sequence_decoder: directed scenarios plus random
// segment traffic against a digit-level reference model (honours SEG_DP_CHECK_EN).
module tb_seg_sequence_decoder;
    localparam int NBITS_SEG     = 8;
    localparam int STABLE_CYCLES = 2;
    localparam int LOCK_COUNT    = 2;
    localparam int NBITS_ERR     = 8;
    localparam int ERR_MAX       = (1 << NBITS_ERR) - 1;

    logic clk_2   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_2 = ~clk_2;

    seg_sequence_decoder_if #(.NBITS_SEG(NBITS_SEG), .NBITS_ERR(NBITS_ERR)) bus ();

    seg_sequence_decoder #(
        .NBITS_SEG(NBITS_SEG), .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_COUNT(LOCK_COUNT), .NBITS_ERR(NBITS_ERR)
    ) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: last sample and its run length, last accepted digit,
    // tracker mode (0 hunting, 1 syncing, 2 locked), last in-order digit, match count.
    int m_prev, m_run, m_value, m_vv, m_acc, m_serr, m_err;
    int m_mode, m_last, m_matches;

    function automatic int mask_dp(input int s);
`ifdef SEG_DP_CHECK_EN
        return s & 8'hFF;
`else
        return s & 8'h7F;
`endif
    endfunction

    function automatic int digit_of(input int s);
        case (s)
            8'h06:   return 1;
            8'h5B:   return 2;
            8'h66:   return 4;
            8'h7F:   return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int idx_of(input int d);
        case (d)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int succ(input int d);
        return (d == 8) ? 1 : d * 2;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_value = 0; m_vv = 0; m_acc = 0; m_serr = 0;
        m_err = 0; m_mode = 0; m_last = 0; m_matches = 0;
    endtask

    task automatic model_step(input bit en, input int seg, input bit clr);
        int  s, d;
        bit  rep, viol;
        m_acc  = 0;
        m_serr = 0;
        viol   = 0;
        if (en) begin
            s = mask_dp(seg);
            if (s == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else             m_run = 1;
            m_prev = s;
            if (m_run == STABLE_CYCLES) begin
                m_acc   = 1;
                d       = digit_of(s);
                rep     = (d != 0) && (m_vv != 0) && (d == m_value);
                m_value = d;
                m_vv    = (d != 0);
                if (!rep) begin
                    if (m_mode == 0) begin
                        if (d != 0) begin m_mode = 1; m_last = d; m_matches = 0; end
                    end else if (m_mode == 1) begin
                        if (d == 0) m_mode = 0;
                        else if (d == succ(m_last)) begin
                            m_matches++;
                            m_last = d;
                            if (m_matches >= LOCK_COUNT) m_mode = 2;
                        end else begin
                            m_last = d; m_matches = 0;
                        end
                    end else begin
                        if (d != 0 && d == succ(m_last)) m_last = d;
                        else begin m_mode = 0; viol = 1; m_serr = 1; end
                    end
                end
            end
        end
        if (clr) m_err = 0;
        else if (viol && m_err < ERR_MAX) m_err++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        check("value",       32'(bus.value),       m_value);
        check("code_idx",    32'(bus.code_idx),    idx_of(m_value));
        check("value_valid", 32'(bus.value_valid), m_vv);
        check("accepted",    32'(bus.accepted),    m_acc);
        check("locked",      32'(bus.locked),      (m_mode == 2) ? 1 : 0);
        check("seq_error",   32'(bus.seq_error),   m_serr);
        check("err_count",   32'(bus.err_count),   m_err);
    endtask

    task automatic cycle(input bit en, input logic [7:0] seg, input bit clr);
        bus.sample_en = en;
        bus.seg_in    = seg;
        bus.clear_err = clr;
        @(posedge clk_2);
        model_step(en, int'(seg), clr);
        @(negedge clk_2);
        cyc++;
        check_all();
    endtask

    task automatic hold(input logic [7:0] seg, input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, seg, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"},  32'(bus.value),       0);
        check({tag, "_valid"},  32'(bus.value_valid), 0);
        check({tag, "_acc"},    32'(bus.accepted),    0);
        check({tag, "_locked"}, 32'(bus.locked),      0);
        check({tag, "_serr"},   32'(bus.seq_error),   0);
        check({tag, "_err"},    32'(bus.err_count),   0);
    endtask

    // Called at a negedge; asserts reset between edges and checks it acts at once.
    task automatic async_reset(input string tag);
        bus.sample_en = 1'b0;
        bus.clear_err = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk_2);
        @(negedge clk_2);
        reset_n = 1'b1;
    endtask

    task automatic random_phase(input int n);
        logic [7:0] codes [4];
        logic [7:0] pat;
        int         left, pos, r;
        codes[0] = 8'h06; codes[1] = 8'h5B; codes[2] = 8'h66; codes[3] = 8'h7F;
        left = 0; pos = 0; pat = 8'h06;
        for (int i = 0; i < n; i++) begin
            if (left == 0) begin
                r = $urandom_range(0, 99);
                if (r < 65)      begin pos = (pos + 1) % 4; pat = codes[pos]; end
                else if (r < 75) pat = codes[$urandom_range(0, 3)];
                else if (r < 83) pat = 8'h3F;
                else if (r < 90) pat = 8'h00;
                else if (r < 95) pat = codes[$urandom_range(0, 3)] | 8'h80;
                else             pat = 8'($urandom_range(0, 255));
                left = $urandom_range(1, 3);
            end
            left--;
            cycle(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, pat,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.seg_in    = '0;
        bus.clear_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_2);
        check_zero("reset");
        reset_n = 1'b1;

        // Nominal 1-2-4-8 walk and wrap.
        hold(8'h06, 2);
        check("nom_value1", 32'(bus.value), 1);
        check("nom_acc1",   32'(bus.accepted), 1);
        hold(8'h5B, 2);
        check("nom_value2", 32'(bus.value), 2);
        hold(8'h66, 2);
        check("nom_locked_at4", 32'(bus.locked), 1);
        hold(8'h7F, 2);
        check("nom_value8", 32'(bus.value), 8);
        check("nom_idx8",   32'(bus.code_idx), 3);
        hold(8'h06, 2);
        check("wrap_locked", 32'(bus.locked), 1);
        check("wrap_err",    32'(bus.err_count), 0);

        // Skip 1 -> 4 while locked.
        hold(8'h66, 2);
        check("skip_serr",   32'(bus.seq_error), 1);
        check("skip_err",    32'(bus.err_count), 1);
        check("skip_locked", 32'(bus.locked), 0);
        cycle(1'b1, 8'h66, 1'b0);
        check("skip_pulse_end", 32'(bus.seq_error), 0);

        // Relock, then a one-sample glitch on 0x5B.
        hold(8'h7F, 2); hold(8'h06, 2); hold(8'h5B, 2);
        check("relock", 32'(bus.locked), 1);
        hold(8'h00, 1);
        hold(8'h5B, 2);
        check("glitch_locked", 32'(bus.locked), 1);
        check("glitch_err",    32'(bus.err_count), 1);

        // Invalid pattern while locked, then freeze with sample_en low.
        hold(8'h3F, 2);
        check("inv_value", 32'(bus.value), 0);
        check("inv_valid", 32'(bus.value_valid), 0);
        check("inv_err",   32'(bus.err_count), 2);
        for (int k = 0; k < 5; k++) cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0);
        check("freeze_err",    32'(bus.err_count), 2);
        check("freeze_locked", 32'(bus.locked), 0);

        // Saturation, then clear winning over a simultaneous violation.
        for (int k = 0; k < 260; k++) begin
            hold(8'h06, 2); hold(8'h5B, 2); hold(8'h66, 2); hold(8'h3F, 2);
        end
        check("sat_err", 32'(bus.err_count), 255);
        hold(8'h06, 2); hold(8'h5B, 2); hold(8'h66, 2);
        cycle(1'b1, 8'h3F, 1'b0);
        cycle(1'b1, 8'h3F, 1'b1);
        check("clr_serr", 32'(bus.seq_error), 1);
        check("clr_err",  32'(bus.err_count), 0);

        random_phase(1500);
        async_reset("midrst");
        random_phase(1500);

        // Decimal point handling.
        async_reset("dprst");
        hold(8'h86, 2);
`ifdef SEG_DP_CHECK_EN
        check("dp_value", 32'(bus.value), 0);
        check("dp_valid", 32'(bus.value_valid), 0);
`else
        check("dp_value", 32'(bus.value), 1);
        check("dp_valid", 32'(bus.value_valid), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
